// File: rtl/mux_pipe_reg.sv
// mux_pipe_reg: N-way WIDTH-bit select mux feeding a STAGES-deep valid/stall/flush pipeline.
// Define MUX_SEL_ERR_CNT_EN to add the saturating out-of-range select counter on err_cnt.
module mux_pipe_reg #(
  parameter int              WIDTH     = 32,
  parameter int              N         = 4,
  parameter int              STAGES    = 1,
  parameter logic [WIDTH-1:0] DEF_VAL  = {WIDTH{1'b0}},
  parameter int              ERR_CNT_W = 8,
  localparam int             SELW      = (N <= 2) ? 1 : $clog2(N)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [N*WIDTH-1:0] x_flat,
  input  logic [SELW-1:0]    sel,
  input  logic               in_valid,
  input  logic               stall,
  input  logic               flush,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_valid,
  output logic               sel_err
`ifdef MUX_SEL_ERR_CNT_EN
  ,
  output logic [ERR_CNT_W-1:0] err_cnt
`endif
);

  localparam bit POW2 = ((1 << SELW) == N);

  logic [WIDTH-1:0] mux_data_s;
  logic             oor_s;
  logic [WIDTH-1:0] ld_data_s;
  logic             ld_err_s;
  logic             load_s;

  logic [WIDTH-1:0] data_r [STAGES];
  logic [STAGES-1:0] valid_r;
  logic [STAGES-1:0] err_r;

  generate
    if (POW2) begin : g_pow2
      // Every sel encoding names a real channel, so no out-of-range case exists.
      always_comb begin
        mux_data_s = x_flat[int'(sel)*WIDTH +: WIDTH];
        oor_s      = 1'b0;
      end
    end else begin : g_npow2
      // Encodings at or above N fall back to DEF_VAL and raise oor.
      always_comb begin
        mux_data_s = DEF_VAL;
        oor_s      = 1'b1;
        if (sel < SELW'(N)) begin
          mux_data_s = x_flat[int'(sel)*WIDTH +: WIDTH];
          oor_s      = 1'b0;
        end else begin
          mux_data_s = DEF_VAL;
          oor_s      = 1'b1;
        end
      end
    end
  endgenerate

  // Stage-1 load value: a bubble carries zero data and never an error.
  always_comb begin
    ld_data_s = {WIDTH{1'b0}};
    ld_err_s  = 1'b0;
    load_s    = ~flush & ~stall;
    if (in_valid) begin
      ld_data_s = mux_data_s;
      ld_err_s  = oor_s;
    end else begin
      ld_data_s = {WIDTH{1'b0}};
      ld_err_s  = 1'b0;
    end
  end

  // Pipeline registers: reset > flush > stall(hold) > load/shift.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < STAGES; k++) begin
        data_r[k] <= {WIDTH{1'b0}};
      end
      valid_r <= {STAGES{1'b0}};
      err_r   <= {STAGES{1'b0}};
    end else if (flush) begin
      for (int k = 0; k < STAGES; k++) begin
        data_r[k] <= {WIDTH{1'b0}};
      end
      valid_r <= {STAGES{1'b0}};
      err_r   <= {STAGES{1'b0}};
    end else if (load_s) begin
      data_r[0]  <= ld_data_s;
      valid_r[0] <= in_valid;
      err_r[0]   <= ld_err_s;
      for (int k = 1; k < STAGES; k++) begin
        data_r[k]  <= data_r[k-1];
        valid_r[k] <= valid_r[k-1];
        err_r[k]   <= err_r[k-1];
      end
    end
  end

  assign out_data  = data_r[STAGES-1];
  assign out_valid = valid_r[STAGES-1];
  assign sel_err   = err_r[STAGES-1];

`ifdef MUX_SEL_ERR_CNT_EN
  logic [ERR_CNT_W-1:0] err_cnt_r;

  // Saturating count of accepted out-of-range beats; only reset_n clears it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_cnt_r <= {ERR_CNT_W{1'b0}};
    end else if (load_s && in_valid && oor_s && (err_cnt_r != {ERR_CNT_W{1'b1}})) begin
      err_cnt_r <= err_cnt_r + ERR_CNT_W'(1);
    end
  end

  assign err_cnt = err_cnt_r;
`endif

endmodule
